// File: rtl/ibus_bridge_pkg.sv
// Shared definitions for the instruction-fetch bus bridge: state encodings,
// timeout counter width and reset polarity.
package ibus_bridge_pkg;

    localparam int unsigned TMO_W      = 8;
    localparam logic        RST_ENABLE = 1'b0;

    typedef enum logic {
        IBUS_IDLE = 1'b0,
        IBUS_REQ  = 1'b1
    } ibus_state_e;

endpackage

// File: rtl/ibus_timeout_cnt.sv
// Fetch timeout counter: synchronous clear, count enable, terminal-count flag.
module ibus_timeout_cnt
    import ibus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal_c
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // Terminal on the last REQ cycle that may still see an ack.
    assign terminal_c = (cnt == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ibus_bridge.sv
// Instruction-fetch bridge: one-entry fetch buffer in front of a variable-latency
// req/ack instruction bus; misses stall the core until the buffer is refilled.
module ibus_bridge
    import ibus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              stall_req_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);

    ibus_state_e       state_q, state_d;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [DATA_W-1:0] buf_data;
    logic [ADDR_W-1:0] req_addr;
    logic              err_q;

    logic              hit_c;
    logic              load_req_c;
    logic              fill_c;
    logic [DATA_W-1:0] fill_data_c;
    logic              err_d_c;
    logic              cnt_clr_c;
    logic              cnt_en_c;
    logic              terminal_c;

    ibus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr_c),
        .en         (cnt_en_c),
        .terminal_c (terminal_c)
    );

    assign hit_c = rom_ce_i & buf_valid & (rom_addr_i == buf_tag);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= IBUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and buffer/counter controls; an ack beats a same-cycle timeout
    always_comb begin
        state_d     = state_q;
        load_req_c  = 1'b0;
        fill_c      = 1'b0;
        fill_data_c = '0;
        err_d_c     = 1'b0;
        cnt_clr_c   = 1'b0;
        cnt_en_c    = 1'b0;
        case (state_q)
            IBUS_IDLE: begin
                if (rom_ce_i && !hit_c) begin
                    state_d    = IBUS_REQ;
                    load_req_c = 1'b1;
                    cnt_clr_c  = 1'b1;
                end
            end
            IBUS_REQ: begin
                if (bus_ack_i) begin
                    state_d     = IBUS_IDLE;
                    fill_c      = 1'b1;
                    fill_data_c = bus_rdata_i;
                end else if (terminal_c) begin
                    state_d = IBUS_IDLE;
                    fill_c  = 1'b1;
                    err_d_c = 1'b1;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            default: state_d = IBUS_IDLE;
        endcase
    end

    // Fetch buffer, latched request address and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            req_addr  <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d_c;
            if (load_req_c) begin
                req_addr <= rom_addr_i;
            end
            if (fill_c) begin
                buf_valid <= 1'b1;
                buf_tag   <= req_addr;
                buf_data  <= fill_data_c;
            end
        end
    end

    assign bus_req_o  = (state_q == IBUS_REQ);
    assign bus_addr_o = req_addr;
    assign bus_err_o  = err_q;

    // Core-facing outputs are combinational so a hit costs no cycle; gated low in reset.
    assign rom_data_o  = (rst != RST_ENABLE && hit_c) ? buf_data : '0;
    assign stall_req_o = (rst != RST_ENABLE) &&
                         ((rom_ce_i && !hit_c) || (state_q == IBUS_REQ));

endmodule

// File: tb/tb_ibus_bridge.sv
// Directed testbench for ibus_bridge: cold fetch, hits, misses, timeout,
// redirect and reset during an outstanding request.
module tb_ibus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    ibus_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce),
        .rom_addr_i  (rom_addr),
        .rom_data_o  (rom_data),
        .stall_req_o (stall),
        .bus_req_o   (bus_req),
        .bus_addr_o  (bus_addr),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata),
        .bus_err_o   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch one address until the core is no longer stalled; acks on the Nth
    // request cycle (0 = never) and reports what was observed.
    task automatic run_fetch(input logic [31:0] addr, input int ack_after,
                             input logic [31:0] rdata, output int stalls,
                             output int reqs, output int errs,
                             output logic [31:0] data, output logic [31:0] last_addr,
                             output bit done);
        stalls = 0; reqs = 0; errs = 0; data = '0; last_addr = '0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            rom_ce = 1'b1; rom_addr = addr; bus_ack = 1'b0; bus_rdata = rdata;
            if (bus_req) begin
                reqs++;
                last_addr = bus_addr;
                if (ack_after != 0 && reqs == ack_after) bus_ack = 1'b1;
            end
            @(negedge clk);
            if (bus_err) errs++;
            if (stall) stalls++;
            else begin data = rom_data; done = 1'b1; end
            tick();
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rom_ce = 1'b1; rom_addr = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        total++; if (rom_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rom_data); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", bus_req); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus_addr); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", bus_err); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_cold_fetch();
        int s, r, e; logic [31:0] d, a; bit ok;
        run_fetch(32'h0, 3, 32'h3401_1100, s, r, e, d, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL cold_done got=timeout exp=done"); end
        total++; if (s != 4) begin bad++; $display("FAIL cold_stalls got=%0d exp=4", s); end
        total++; if (r != 3) begin bad++; $display("FAIL cold_reqs got=%0d exp=3", r); end
        total++; if (a !== 32'h0) begin bad++; $display("FAIL cold_addr got=%h exp=0", a); end
        total++; if (d !== 32'h3401_1100) begin bad++; $display("FAIL cold_data got=%h exp=34011100", d); end
    endtask

    task automatic test_repeat_hit();
        for (int i = 0; i < 5; i++) begin
            rom_ce = 1'b1; rom_addr = 32'h0;
            @(negedge clk);
            total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL hit_req[%0d] got=%0b exp=0", i, bus_req); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL hit_stall[%0d] got=%0b exp=0", i, stall); end
            total++; if (rom_data !== 32'h3401_1100) begin bad++; $display("FAIL hit_data[%0d] got=%h exp=34011100", i, rom_data); end
            tick();
        end
    endtask

    task automatic test_seq_miss();
        int s, r, e; logic [31:0] d, a; bit ok;
        run_fetch(32'h4, 1, 32'h3402_0020, s, r, e, d, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL seq_done got=timeout exp=done"); end
        total++; if (s != 2) begin bad++; $display("FAIL seq_stalls got=%0d exp=2", s); end
        total++; if (a !== 32'h4) begin bad++; $display("FAIL seq_addr got=%h exp=4", a); end
        total++; if (d !== 32'h3402_0020) begin bad++; $display("FAIL seq_data got=%h exp=34020020", d); end
    endtask

    task automatic test_timeout();
        int s, r, e; logic [31:0] d, a; bit ok;
        run_fetch(32'h8, 0, 32'hDEAD_BEEF, s, r, e, d, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_done got=timeout exp=done"); end
        total++; if (r != 16) begin bad++; $display("FAIL tmo_reqs got=%0d exp=16", r); end
        total++; if (e != 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", e); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL tmo_data got=%h exp=0", d); end
        // late ack in IDLE must not touch the buffer
        rom_ce = 1'b1; rom_addr = 32'h8; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL tmo_err_pulse got=%0b exp=0", bus_err); end
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        total++; if (rom_data !== 32'h0) begin bad++; $display("FAIL late_ack_data got=%h exp=0", rom_data); end
        total++; if (stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL late_ack_idle got=%0b%0b exp=00", stall, bus_req); end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        int s, r, e; logic [31:0] d, a; bit ok;
        run_fetch(32'h20, 16, 32'h2442_0001, s, r, e, d, a, ok);
        total++; if (!ok) begin bad++; $display("FAIL acktmo_done got=timeout exp=done"); end
        total++; if (r != 16) begin bad++; $display("FAIL acktmo_reqs got=%0d exp=16", r); end
        total++; if (e != 0) begin bad++; $display("FAIL acktmo_err got=%0d exp=0", e); end
        total++; if (d !== 32'h2442_0001) begin bad++; $display("FAIL acktmo_data got=%h exp=24420001", d); end
    endtask

    task automatic test_redirect();
        rom_ce = 1'b1; rom_addr = 32'hC; bus_ack = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL redir_miss got=%0b exp=1", stall); end
        tick();
        rom_addr = 32'h100; bus_ack = 1'b1; bus_rdata = 32'h3C01_0000;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'hC) begin bad++; $display("FAIL redir_req got=%0b/%h exp=1/c", bus_req, bus_addr); end
        tick();
        bus_ack = 1'b0; rom_addr = 32'hC;
        #1;
        total++; if (stall !== 1'b0 || rom_data !== 32'h3C01_0000) begin bad++; $display("FAIL redir_tag got=%0b/%h exp=0/3c010000", stall, rom_data); end
        rom_addr = 32'h100;
        @(negedge clk);
        total++; if (stall !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL redir_gap got=%0b%0b exp=10", stall, bus_req); end
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h8C22_0000;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin bad++; $display("FAIL redir_new got=%0b/%h exp=1/100", bus_req, bus_addr); end
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0 || rom_data !== 32'h8C22_0000) begin bad++; $display("FAIL redir_fill got=%0b/%h exp=0/8c220000", stall, rom_data); end
        tick();
    endtask

    task automatic test_reset_mid_request();
        rom_ce = 1'b1; rom_addr = 32'h300; bus_ack = 1'b0;
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%0b exp=1", bus_req); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0 || stall !== 1'b0 || rom_data !== 32'h0) begin bad++; $display("FAIL rstmid_async got=%0b%0b/%h exp=00/0", bus_req, stall, rom_data); end
        tick();
        rst = 1'b1; rom_addr = 32'h100; bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        total++; if (stall !== 1'b1 || rom_data !== 32'h0) begin bad++; $display("FAIL rstmid_miss got=%0b/%h exp=1/0", stall, rom_data); end
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin bad++; $display("FAIL rstmid_refetch got=%0b/%h exp=1/100", bus_req, bus_addr); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_fetch();
        test_repeat_hit();
        test_seq_miss();
        test_timeout();
        test_ack_at_timeout();
        test_redirect();
        test_reset_mid_request();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibus_bridge.md
Name: ibus_bridge

Overview:
- Instruction-fetch bridge between the chino core fetch port (rom_ce_o/rom_addr_o/rom_data_i) and a variable-latency req/ack instruction bus.
- Holds a one-entry fetch buffer (tag + data).
- A hit returns the instruction combinationally. A miss raises stall_req_o and runs a bus transaction.
- stall_req_o is routed to the pipeline stall controller (ctrl) being added alongside this block.

Parameters:
- ADDR_W, 32, width of fetch and bus address (matches `InstAddrBus).
- DATA_W, 32, width of instruction word (matches `InstBus).
- TIMEOUT_CYCLES, 16, bus cycles to wait for bus_ack_i before aborting the fetch; legal range 2..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_ce_i  in  1  fetch enable from core.
- rom_addr_i  in  ADDR_W  fetch address from core.
- rom_data_o  out  DATA_W  instruction returned to core.
- stall_req_o  out  1  fetch not satisfied this cycle; core must hold PC.
- bus_req_o  out  1  bus read request.
- bus_addr_o  out  ADDR_W  bus read address.
- bus_ack_i  in  1  single-cycle read acknowledge.
- bus_rdata_i  in  DATA_W  read data, valid when bus_ack_i=1.
- bus_err_o  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- State: FSM {IDLE, REQ}, buf_valid, buf_tag[ADDR_W], buf_data[DATA_W], req_addr[ADDR_W], tmo_cnt[8].
- Reset (rst=0, asynchronous):
  - state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, req_addr=0, tmo_cnt=0.
  - bus_req_o=0, bus_addr_o=0, bus_err_o=0.
  - rom_data_o=0, stall_req_o=0.
  - Any in-flight request is dropped immediately. An ack arriving after reset release is ignored.
- Hit (combinational): hit = rom_ce_i & buf_valid & (rom_addr_i==buf_tag).
- Outputs:
  - rom_ce_i=0: rom_data_o=0 (NOP), stall_req_o=0.
  - rom_ce_i=1 & hit: rom_data_o=buf_data, stall_req_o=0.
  - rom_ce_i=1 & !hit: rom_data_o=0, stall_req_o=1. Stall also holds while state=REQ.
- IDLE:
  - On rom_ce_i & !hit, latch req_addr=rom_addr_i, clear tmo_cnt, go to REQ.
  - bus_req_o rises on the next cycle.
- REQ:
  - bus_req_o=1 and bus_addr_o=req_addr, stable until exit.
  - bus_ack_i=1: buf_data=bus_rdata_i, buf_tag=req_addr, buf_valid=1, go to IDLE. bus_req_o drops next cycle.
  - No ack: tmo_cnt++.
  - tmo_cnt==TIMEOUT_CYCLES-1 with no ack: buf_data=0, buf_tag=req_addr, buf_valid=1, bus_err_o=1 for one cycle, go to IDLE. The core then retires a NOP.
  - Ack and timeout in the same cycle: the ack wins and bus_err_o stays 0.
- Latency:
  - Miss on cycle t puts bus_req_o high on t+1.
  - Ack on cycle t+k makes the buffer valid on t+k+1; the hit returns data with stall_req_o=0 on that cycle.
  - Minimum miss penalty is 2 cycles.
- Address change while in REQ (e.g. branch redirect): the transaction completes with the latched req_addr and the buffer is filled. IDLE then re-evaluates; a mismatch triggers a new miss. Requests are never aborted mid-flight.
- bus_ack_i in IDLE is ignored.
- bus_req_o is low for at least one cycle between consecutive transactions.
- rom_ce_i falling during REQ: the transaction still completes and the buffer is filled; stall_req_o follows state (1 while in REQ).
- Address compare is full-width; there is no alignment check.

Decomposition:
- Shared defines.v gains:
  - IBUS_IDLE/IBUS_REQ state encodings.
  - `ZeroWord reuse for NOP/reset data.
  - `RstEnable redefined as 1'b0 for active-low reset.
- Sub-module ibus_timeout_cnt: the clear/enable/terminal-count counter. The FSM and buffer stay in ibus_bridge.

Test Plan:
- Cold fetch: release reset, rom_ce_i=1, rom_addr_i=0x00000000, bus acks after 3 cycles with 0x34011100 -> stall_req_o=1 for 4 cycles, bus_req_o high for 3 cycles with bus_addr_o=0, then rom_data_o=0x34011100 and stall_req_o=0.
- Repeat hit: hold rom_addr_i=0x00000000 for 5 further cycles -> bus_req_o stays 0, rom_data_o=0x34011100, stall_req_o=0 every cycle.
- Sequential miss: rom_addr_i 0x0 -> 0x4, ack in first REQ cycle with 0x34020020 -> exactly 2 stall cycles, bus_addr_o=0x4, then data returned.
- Timeout: miss at 0x8, no ack -> bus_req_o high 16 cycles, one-cycle bus_err_o pulse, rom_data_o=0x00000000, stall_req_o=0 on the next cycle; a late ack is ignored.
- Redirect mid-request: miss at 0xC, rom_addr_i changes to 0x100 during REQ, ack at 0xC -> buffer tag=0xC, new request issued with bus_addr_o=0x100.
- Reset mid-request: assert rst=0 while bus_req_o=1 -> bus_req_o, stall_req_o and rom_data_o are 0 asynchronously; after release, a fetch of the previous address misses.
